// File: rtl/dmem_responder.sv
// Data-memory responder: memory side of the pipeline's load/store interface.
// Little-endian byte-addressed array, byte-lane writes, right-justified load data,
// configurable wait states, error flag for misaligned/out-of-range/reserved accesses.
// Optional console/cycle-counter registers at 0xFFFF_0000..7 when DMEM_MMIO_EN is defined.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_valid,
  output logic        Req_ready,
  input  logic        Req_we,
  input  logic [1:0]  Req_size,
  input  logic [31:0] Req_addr,
  input  logic [7:0]  Req_wr1,
  input  logic [7:0]  Req_wr2,
  input  logic [7:0]  Req_wr3,
  input  logic [7:0]  Req_wr4,
  output logic        Resp_valid,
  output logic        Resp_err,
  output logic [31:0] Resp_rdata
`ifdef DMEM_MMIO_EN
  ,
  output logic [7:0]  Mmio_tx_data,
  output logic        Mmio_tx_valid
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StExec, StResp} state_e;

  localparam logic [3:0] WaitLast = 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [1 << ADDR_W];

  logic              accept;
  logic [31:0]       off;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_idx;
  logic              misalign;
  logic              out_of_range;
  logic              err;
  logic              commit;
  logic              commit_wr;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_data;
  logic [3:0]        be;
  logic [31:0]       wd;

  assign accept   = (state_q == StIdle) && Req_valid;
  assign off      = addr_q - BASE_ADDR;
  assign lane     = off[1:0];
  assign word_idx = off[ADDR_W+1:2];

  assign misalign = ((size_q == 2'b01) && lane[0]) ||
                    ((size_q == 2'b10) && (lane != 2'b00)) ||
                    (size_q == 2'b11);
  assign out_of_range = (addr_q < BASE_ADDR) || ((off >> (ADDR_W + 2)) != 32'd0);

`ifdef DMEM_MMIO_EN
  logic        mmio_win;
  logic        con_hit;
  logic        cnt_hit;
  logic [31:0] cyc_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  assign mmio_win = (addr_q[31:3] == 29'h1FFF_E000);
  assign con_hit  = (addr_q == 32'hFFFF_0000) && we_q && (size_q == 2'b00);
  assign cnt_hit  = (addr_q == 32'hFFFF_0004) && !we_q && (size_q == 2'b10);
  // MMIO window takes priority over the array decode.
  assign err      = mmio_win ? !(con_hit || cnt_hit) : (misalign || out_of_range);
  assign commit_wr = commit && we_q && !err && !mmio_win;
  assign Mmio_tx_data  = tx_data_q;
  assign Mmio_tx_valid = tx_valid_q;
`else
  assign err       = misalign || out_of_range;
  assign commit_wr = commit && we_q && !err;
`endif

  // A reset on the commit edge drops the store.
  assign commit = (state_q == StExec) && !Reset;

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  // Load formatting and store lane alignment, decoded from the latched size.
  always_comb begin
    load_data = rd_word;
    be        = 4'b0000;
    wd        = wdata_q;
    unique case (size_q)
      2'b00: begin
        load_data = {24'd0, rd_shift[7:0]};
        be        = 4'b0001 << lane;
        wd        = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_data = {16'd0, rd_shift[15:0]};
        be        = 4'b0011 << lane;
        wd        = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        load_data = rd_word;
        be        = 4'b1111;
        wd        = wdata_q;
      end
      default: begin
        load_data = 32'd0;
        be        = 4'b0000;
      end
    endcase
  end

  // Array write on the commit edge; contents are never reset.
  always_ff @(posedge Clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    Req_ready  = 1'b0;
    Resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        Req_ready = 1'b1;
        if (Req_valid) state_d = (WAIT_STATES > 0) ? StWait : StExec;
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = 4'd0;
          state_d = StExec;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        Resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Resp_err   = Resp_valid && err_q;
  assign Resp_rdata = rdata_q;

  // State, request latch and response capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= Req_we;
        size_q  <= Req_size;
        addr_q  <= Req_addr;
        wdata_q <= {Req_wr4, Req_wr3, Req_wr2, Req_wr1};
      end
      if (commit) begin
        err_q <= err;
        if (err) begin
          rdata_q <= 32'd0;
        end else if (!we_q) begin
`ifdef DMEM_MMIO_EN
          rdata_q <= cnt_hit ? cyc_q : load_data;
`else
          rdata_q <= load_data;
`endif
        end
      end
    end
  end

`ifdef DMEM_MMIO_EN
  // Free-running cycle counter and console register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_q      <= 32'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_q + 32'd1;
      tx_valid_q <= commit && con_hit;
      if (commit && con_hit) tx_data_q <= wdata_q[7:0];
    end
  end
`endif

endmodule
